// File: rtl/inst_mem.sv
// inst_mem: instruction memory with valid/ready fetch port, fixed stall latency and a program-load write port
module inst_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [31:0] mem [DEPTH];
  logic [31:0] addr_q, rd_addr;
  logic [3:0] cnt;
  logic accept, enter, rd_bad, ld_ok;
  always_comb begin
    req_ready = rst_n && (state == IDLE || (state == RESP && resp_ready));
    accept = req_valid && req_ready;
    nxt = state;
    if (accept) nxt = WAIT_CYCLES == 0 ? RESP : WAIT;
    else if (state == WAIT && cnt == 4'd0) nxt = RESP;
    else if (state == RESP && resp_ready) nxt = IDLE;
  end
  assign enter = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  assign rd_addr = state == WAIT ? addr_q : req_addr;
  assign resp_valid = state == RESP;
`ifdef IMEM_FAULT_EN
  assign rd_bad = |rd_addr[1:0] || rd_addr[31:2] >= 30'(DEPTH);
  assign ld_ok = ~|ld_addr[1:0] && ld_addr[31:2] < 30'(DEPTH);
`else
  logic unused_bits;
  assign rd_bad = 1'b0;
  assign ld_ok = 1'b1;
  assign unused_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      resp_data <= '0;
      resp_fault <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q <= req_addr;
        cnt <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (enter) begin
        resp_data <= rd_bad ? '0 : mem[rd_addr[AW+1:2]];
        resp_fault <= rd_bad;
      end
    end
  always_ff @(posedge clk)
    if (rst_n && ld_we && ld_ok) mem[ld_addr[AW+1:2]] <= ld_data;
endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed self-checking bench for inst_mem with a zero-stall (a_) and a 3-stall (b_) instance.
module tb_inst_mem;
  logic clk = 0, rst_n = 0;
  logic ld_we = 0;
  logic [31:0] ld_addr = 0, ld_data = 0;
  logic a_req_valid = 0, a_resp_ready = 0, a_req_ready, a_resp_valid, a_resp_fault;
  logic [31:0] a_req_addr = 0, a_resp_data;
  logic b_req_valid = 0, b_resp_ready = 0, b_req_ready, b_resp_valid, b_resp_fault;
  logic [31:0] b_req_addr = 0, b_resp_data;
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  inst_mem #(.DEPTH(64), .WAIT_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data), .resp_fault(a_resp_fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  inst_mem #(.DEPTH(64), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data), .resp_fault(b_resp_fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [31:0] addr, input logic [31:0] data);
    ld_we = 1; ld_addr = addr; ld_data = data;
    tick();
    ld_we = 0;
  endtask

  task automatic a_fetch(input logic [31:0] addr, output logic v, output logic [31:0] d, output logic f);
    a_req_valid = 1; a_req_addr = addr; a_resp_ready = 1;
    tick();
    a_req_valid = 0;
    v = a_resp_valid; d = a_resp_data; f = a_resp_fault;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    vec++; if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b/%b want 0/0", a_resp_valid, b_resp_valid); end
    vec++; if (a_resp_data !== 32'h0 || b_resp_data !== 32'h0) begin errs++; $display("FAIL rst_data got %h/%h want 0/0", a_resp_data, b_resp_data); end
    vec++; if (a_resp_fault !== 1'b0 || b_resp_fault !== 1'b0) begin errs++; $display("FAIL rst_fault got %b/%b want 0/0", a_resp_fault, b_resp_fault); end
    vec++; if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_low got %b/%b want 0/0", a_req_ready, b_req_ready); end
    rst_n = 1;
    #1;
    vec++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin errs++; $display("FAIL idle_ready got %b/%b want 1/1", a_req_ready, b_req_ready); end
  endtask

  task automatic test_load_read();
    logic v, f;
    logic [31:0] d;
    ld(32'h4, 32'h00100093);
    ld(32'h0, 32'h11111111);
    ld(32'h8, 32'h22222222);
    ld(32'hC, 32'h33333333);
    a_fetch(32'h4, v, d, f);
    vec++; if (v !== 1'b1) begin errs++; $display("FAIL rd4_valid got %b want 1", v); end
    vec++; if (d !== 32'h00100093) begin errs++; $display("FAIL rd4_data got %h want 00100093", d); end
    vec++; if (f !== 1'b0) begin errs++; $display("FAIL rd4_fault got %b want 0", f); end
    a_fetch(32'h0, v, d, f);
    vec++; if (d !== 32'h11111111) begin errs++; $display("FAIL rd0_data got %h want 11111111", d); end
    a_fetch(32'hC, v, d, f);
    vec++; if (d !== 32'h33333333) begin errs++; $display("FAIL rdC_data got %h want 33333333", d); end
    vec++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL idle_after_consume got %b want 0", a_resp_valid); end
  endtask

  task automatic test_wait();
    b_resp_ready = 1; b_req_valid = 1; b_req_addr = 32'h8;
    tick();
    b_req_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      vec++; if (b_resp_valid !== (k == 4)) begin errs++; $display("FAIL wait_valid_c%0d got %b want %b", k, b_resp_valid, k == 4); end
      if (k < 4) begin
        vec++; if (b_req_ready !== 1'b0) begin errs++; $display("FAIL wait_ready_c%0d got %b want 0", k, b_req_ready); end
      end
    end
    vec++; if (b_resp_data !== 32'h22222222) begin errs++; $display("FAIL wait_data got %h want 22222222", b_resp_data); end
    b_req_valid = 1; b_req_addr = 32'hC;
    tick();
    b_req_valid = 0;
    vec++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0) begin errs++; $display("FAIL b2b_wait got valid %b ready %b want 0 0", b_resp_valid, b_req_ready); end
    tick(); tick();
    vec++; if (b_resp_valid !== 1'b0) begin errs++; $display("FAIL b2b_early got %b want 0", b_resp_valid); end
    tick();
    vec++; if (b_resp_valid !== 1'b1 || b_resp_data !== 32'h33333333) begin errs++; $display("FAIL b2b_resp got valid %b data %h want 1 33333333", b_resp_valid, b_resp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    a_resp_ready = 0; a_req_valid = 1; a_req_addr = 32'h8;
    tick();
    a_req_valid = 0;
    for (int k = 0; k < 5; k++) begin
      vec++; if (a_resp_valid !== 1'b1 || a_resp_data !== 32'h22222222 || a_req_ready !== 1'b0) begin errs++; $display("FAIL hold_c%0d got valid %b data %h ready %b want 1 22222222 0", k, a_resp_valid, a_resp_data, a_req_ready); end
      tick();
    end
    a_resp_ready = 1; a_req_valid = 1; a_req_addr = 32'hC;
    #1;
    vec++; if (a_req_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready got %b want 1", a_req_ready); end
    tick();
    a_req_valid = 0;
    vec++; if (a_resp_valid !== 1'b1 || a_resp_data !== 32'h33333333) begin errs++; $display("FAIL b2b_nobubble got valid %b data %h want 1 33333333", a_resp_valid, a_resp_data); end
    tick();
    vec++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL consume_idle got %b want 0", a_resp_valid); end
  endtask

  task automatic test_reset_wait();
    logic v, f;
    logic [31:0] d;
    b_resp_ready = 1; b_req_valid = 1; b_req_addr = 32'h4;
    tick();
    b_req_valid = 0;
    tick();
    rst_n = 0; ld_we = 1; ld_addr = 32'h4; ld_data = 32'hDEADBEEF;
    tick();
    ld_we = 0; rst_n = 1;
    #1;
    vec++; if (b_req_ready !== 1'b1) begin errs++; $display("FAIL rstwait_idle got ready %b want 1", b_req_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      vec++; if (b_resp_valid !== 1'b0) begin errs++; $display("FAIL rstwait_noresp_c%0d got %b want 0", k, b_resp_valid); end
    end
    a_fetch(32'h4, v, d, f);
    vec++; if (d !== 32'h00100093) begin errs++; $display("FAIL mem_kept got %h want 00100093", d); end
  endtask

  task automatic test_rbw();
    logic v, f;
    logic [31:0] d;
    a_resp_ready = 1; a_req_valid = 1; a_req_addr = 32'h8;
    ld_we = 1; ld_addr = 32'h8; ld_data = 32'hCAFEF00D;
    tick();
    a_req_valid = 0; ld_we = 0;
    vec++; if (a_resp_data !== 32'h22222222) begin errs++; $display("FAIL rbw_old got %h want 22222222", a_resp_data); end
    tick();
    a_fetch(32'h8, v, d, f);
    vec++; if (d !== 32'hCAFEF00D) begin errs++; $display("FAIL rbw_new got %h want cafef00d", d); end
  endtask

  task automatic test_fault();
    logic v, f;
    logic [31:0] d;
`ifdef IMEM_FAULT_EN
    a_fetch(32'h102, v, d, f);
    vec++; if (v !== 1'b1 || f !== 1'b1 || d !== 32'h0) begin errs++; $display("FAIL fault_mis got v %b f %b d %h want 1 1 0", v, f, d); end
    a_fetch(32'h100, v, d, f);
    vec++; if (f !== 1'b1 || d !== 32'h0) begin errs++; $display("FAIL fault_range got f %b d %h want 1 0", f, d); end
    ld(32'h100, 32'h99999999);
    ld(32'h1, 32'h77777777);
    a_fetch(32'h0, v, d, f);
    vec++; if (f !== 1'b0 || d !== 32'h11111111) begin errs++; $display("FAIL fault_lddrop got f %b d %h want 0 11111111", f, d); end
`else
    a_fetch(32'h100, v, d, f);
    vec++; if (f !== 1'b0 || d !== 32'h11111111) begin errs++; $display("FAIL wrap_100 got f %b d %h want 0 11111111", f, d); end
    a_fetch(32'h106, v, d, f);
    vec++; if (f !== 1'b0 || d !== 32'h00100093) begin errs++; $display("FAIL wrap_106 got f %b d %h want 0 00100093", f, d); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_wait();
    test_back_to_back();
    test_reset_wait();
    test_rbw();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
